// File: rtl/line_sequencer.sv
// Drives an external line generator edge by edge to draw 2-4 vertex polylines or closed
// outlines, forwarding its pixels downstream under a valid/ready handshake.
module line_sequencer #(
  parameter bit SKIP_SHARED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_nverts,
  input  logic        cmd_closed,
  input  logic [47:0] cmd_vx,
  input  logic [47:0] cmd_vy,
  output logic        cmd_error,
  output logic        busy,
  output logic        done,
  output logic        lg_run,
  output logic [11:0] lg_aX,
  output logic [11:0] lg_aY,
  output logic [11:0] lg_bX,
  output logic [11:0] lg_bY,
  output logic        lg_draw_busy,
  output logic        lg_pass_thru_a,
  output logic        lg_pass_thru_b,
  output logic        lg_ena_stop_y,
  output logic [11:0] lg_stop_ypos,
  input  logic        lg_busy,
  input  logic        lg_pixel_data_rdy,
  input  logic        lg_line_complete,
  input  logic [11:0] lg_X,
  input  logic [11:0] lg_Y,
  output logic        pix_valid,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  input  logic        pix_ready
);

  typedef enum logic [2:0] {
    FLUSH = 3'd0,
    IDLE  = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    GAP   = 3'd4,
    EMIT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t      state_r, next_s;
  logic [47:0] vx_r, vy_r;
  logic [2:0]  nverts_r;
  logic        closing_r;
  logic [1:0]  last_e_r;
  logic [1:0]  e_r;
  logic        first_r;
  logic        run_first_r;

  logic        legal_s, closed_s, accept_s;
  logic [2:0]  e_inc_s;
  logic [1:0]  b_idx_s;
  logic [11:0] va_x_s, va_y_s, vb_x_s, vb_y_s;
  logic        closing_edge_s, last_edge_s, drop_run_s, drop_emit_s;

  function automatic logic [11:0] sel12(input logic [47:0] v, input logic [1:0] idx);
    logic [11:0] r;
    case (idx)
      2'd0:    r = v[11:0];
      2'd1:    r = v[23:12];
      2'd2:    r = v[35:24];
      2'd3:    r = v[47:36];
      default: r = 12'd0;
    endcase
    return r;
  endfunction

  assign lg_pass_thru_a = 1'b0;
  assign lg_pass_thru_b = 1'b0;
  assign lg_ena_stop_y  = 1'b0;
  assign lg_stop_ypos   = 12'd0;
  assign cmd_ready      = (state_r == IDLE);

  assign legal_s  = (cmd_nverts >= 3'd2) && (cmd_nverts <= 3'd4);
  assign closed_s = cmd_closed && (cmd_nverts > 3'd2);
  assign accept_s = (state_r == IDLE) && cmd_valid;

  // Endpoint b wraps to V0 on the closing edge.
  assign e_inc_s = {1'b0, e_r} + 3'd1;
  assign b_idx_s = (e_inc_s == nverts_r) ? 2'd0 : e_inc_s[1:0];
  assign va_x_s  = sel12(vx_r, e_r);
  assign va_y_s  = sel12(vy_r, e_r);
  assign vb_x_s  = sel12(vx_r, b_idx_s);
  assign vb_y_s  = sel12(vy_r, b_idx_s);

  assign last_edge_s    = (e_r == last_e_r);
  assign closing_edge_s = closing_r && last_edge_s;
  assign drop_run_s     = SKIP_SHARED && (((e_r != 2'd0) && first_r) ||
                          (closing_edge_s && (lg_X == lg_bX) && (lg_Y == lg_bY)));
  assign drop_emit_s    = SKIP_SHARED && ((e_r != 2'd0) || closing_edge_s);

  // Next-state decode and the combinational pixel/backpressure path.
  always_comb begin
    next_s       = state_r;
    pix_valid    = 1'b0;
    pix_x        = lg_X;
    pix_y        = lg_Y;
    lg_draw_busy = 1'b0;
    case (state_r)
      FLUSH: begin
        if (!lg_busy) next_s = IDLE;
        else          next_s = FLUSH;
      end
      IDLE: begin
        if (cmd_valid && legal_s) next_s = LOAD;
        else                      next_s = IDLE;
      end
      LOAD: begin
        if ((va_x_s == vb_x_s) && (va_y_s == vb_y_s)) next_s = EMIT;
        else                                          next_s = RUN;
      end
      RUN: begin
        pix_valid    = lg_pixel_data_rdy && !drop_run_s;
        lg_draw_busy = pix_valid && !pix_ready;
        // A complete flag still set from the previous edge is visible in the first cycle.
        if (!run_first_r && lg_line_complete) next_s = GAP;
        else                                  next_s = RUN;
      end
      GAP: begin
        if (last_edge_s) next_s = DONE;
        else             next_s = LOAD;
      end
      EMIT: begin
        pix_x     = lg_aX;
        pix_y     = lg_aY;
        pix_valid = !drop_emit_s;
        if (drop_emit_s || pix_ready) begin
          if (last_edge_s) next_s = DONE;
          else             next_s = LOAD;
        end else begin
          next_s = EMIT;
        end
      end
      DONE: begin
        next_s = IDLE;
      end
      default: begin
        next_s = FLUSH;
      end
    endcase
  end

  // State register, command latch, edge bookkeeping and registered generator controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= FLUSH;
      vx_r        <= 48'd0;
      vy_r        <= 48'd0;
      nverts_r    <= 3'd0;
      closing_r   <= 1'b0;
      last_e_r    <= 2'd0;
      e_r         <= 2'd0;
      first_r     <= 1'b0;
      run_first_r <= 1'b0;
      lg_run      <= 1'b0;
      lg_aX       <= 12'd0;
      lg_aY       <= 12'd0;
      lg_bX       <= 12'd0;
      lg_bY       <= 12'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_error   <= 1'b0;
    end else begin
      state_r   <= next_s;
      cmd_error <= accept_s && !legal_s;
      done      <= (next_s == DONE);
      lg_run    <= (next_s == RUN);
      case (state_r)
        IDLE: begin
          if (accept_s && legal_s) begin
            vx_r      <= cmd_vx;
            vy_r      <= cmd_vy;
            nverts_r  <= cmd_nverts;
            closing_r <= closed_s;
            last_e_r  <= cmd_nverts[1:0] - 2'd2 + {1'b0, closed_s};
            e_r       <= 2'd0;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          lg_aX       <= va_x_s;
          lg_aY       <= va_y_s;
          lg_bX       <= vb_x_s;
          lg_bY       <= vb_y_s;
          first_r     <= 1'b1;
          run_first_r <= 1'b1;
        end
        RUN: begin
          run_first_r <= 1'b0;
          if (lg_pixel_data_rdy && !lg_draw_busy) first_r <= 1'b0;
        end
        GAP, EMIT: begin
          if (next_s == LOAD) e_r <= e_r + 2'd1;
        end
        DONE: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= busy;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_sequencer.sv
// Self-checking bench for line_sequencer: a stepping line-generator stand-in, a table of
// directed commands, random polylines against a queue-based pixel model, and reset corners.
module tb_line_sequencer;

  typedef logic [23:0] pt_t;
  typedef pt_t ptq_t[$];

  typedef struct {
    int n;
    bit closed;
    int x0, y0, x1, y1, x2, y2, x3, y3;
    int mode;
    int exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_nverts = 3'd0;
  logic        cmd_closed = 1'b0;
  logic [47:0] cmd_vx = 48'd0, cmd_vy = 48'd0;
  logic        cmd_error, busy, done, lg_run;
  logic [11:0] lg_aX, lg_aY, lg_bX, lg_bY;
  logic        lg_draw_busy, lg_pass_thru_a, lg_pass_thru_b, lg_ena_stop_y;
  logic [11:0] lg_stop_ypos;
  logic        lg_busy = 1'b0, lg_pixel_data_rdy = 1'b0, lg_line_complete = 1'b0;
  logic [11:0] lg_X, lg_Y;
  logic        pix_valid;
  logic [11:0] pix_x, pix_y;
  logic        pix_ready = 1'b1;

  int vectors = 0, miscompares = 0;
  int ready_mode = 0;
  ptq_t got_q;
  int done_cnt = 0, err_cnt = 0, run_rise = 0, db_viol = 0, db_high = 0, flush_viol = 0;
  bit flush_watch = 1'b0;
  logic mon_prev_run = 1'b0;

  always #5 clk = ~clk;

  line_sequencer #(.SKIP_SHARED(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_nverts(cmd_nverts),
    .cmd_closed(cmd_closed), .cmd_vx(cmd_vx), .cmd_vy(cmd_vy),
    .cmd_error(cmd_error), .busy(busy), .done(done),
    .lg_run(lg_run), .lg_aX(lg_aX), .lg_aY(lg_aY), .lg_bX(lg_bX), .lg_bY(lg_bY),
    .lg_draw_busy(lg_draw_busy), .lg_pass_thru_a(lg_pass_thru_a),
    .lg_pass_thru_b(lg_pass_thru_b), .lg_ena_stop_y(lg_ena_stop_y),
    .lg_stop_ypos(lg_stop_ypos), .lg_busy(lg_busy),
    .lg_pixel_data_rdy(lg_pixel_data_rdy), .lg_line_complete(lg_line_complete),
    .lg_X(lg_X), .lg_Y(lg_Y),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_ready(pix_ready)
  );

  function automatic int sx12(input logic [11:0] v);
    return int'($signed(v));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic pt_t mkpt(input int x, input int y);
    return {x[11:0], y[11:0]};
  endfunction

  function automatic logic [47:0] pk(input int a, input int b, input int c, input int d);
    return {d[11:0], c[11:0], b[11:0], a[11:0]};
  endfunction

  // Generator stand-in: steps one Bresenham pixel per cycle it is not held, keeps going when run drops.
  int g_x = 0, g_y = 0, g_x1 = 0, g_y1 = 0, g_dx = 0, g_dy = 0, g_sx = 1, g_sy = 1, g_err = 0;
  logic g_prev_run = 1'b0;
  assign lg_X = g_x[11:0];
  assign lg_Y = g_y[11:0];

  always @(posedge clk) begin
    g_prev_run <= lg_run;
    if (lg_run && !g_prev_run && !lg_busy) begin
      g_x   <= sx12(lg_aX);
      g_y   <= sx12(lg_aY);
      g_x1  <= sx12(lg_bX);
      g_y1  <= sx12(lg_bY);
      g_dx  <= iabs(sx12(lg_bX) - sx12(lg_aX));
      g_dy  <= -iabs(sx12(lg_bY) - sx12(lg_aY));
      g_err <= iabs(sx12(lg_bX) - sx12(lg_aX)) - iabs(sx12(lg_bY) - sx12(lg_aY));
      g_sx  <= (sx12(lg_bX) >= sx12(lg_aX)) ? 1 : -1;
      g_sy  <= (sx12(lg_bY) >= sx12(lg_aY)) ? 1 : -1;
      lg_busy           <= 1'b1;
      lg_pixel_data_rdy <= 1'b1;
      lg_line_complete  <= 1'b0;
    end else if (lg_pixel_data_rdy && !lg_draw_busy) begin
      if (g_x == g_x1 && g_y == g_y1) begin
        lg_pixel_data_rdy <= 1'b0;
        lg_busy           <= 1'b0;
        lg_line_complete  <= 1'b1;
      end else begin
        if (2 * g_err >= g_dy) g_x <= g_x + g_sx;
        if (2 * g_err <= g_dx) g_y <= g_y + g_sy;
        g_err <= g_err + ((2 * g_err >= g_dy) ? g_dy : 0) + ((2 * g_err <= g_dx) ? g_dx : 0);
      end
    end
  end

  // Reference: full pixel list of one segment.
  function automatic ptq_t line_pts(input int x0, input int y0, input int x1, input int y1);
    ptq_t q;
    int dx, dy, sx, sy, err, e2, x, y;
    dx = iabs(x1 - x0);
    dy = -iabs(y1 - y0);
    sx = (x1 >= x0) ? 1 : -1;
    sy = (y1 >= y0) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    for (int k = 0; k < 10000; k++) begin
      q.push_back(mkpt(x, y));
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    return q;
  endfunction

  // Reference: whole command, shared vertices emitted once.
  function automatic ptq_t ref_pixels(input int n, input bit closed, input logic [47:0] vx,
                                      input logic [47:0] vy, output int runs);
    ptq_t all, seg;
    int ne, ax, ay, bx, by, b;
    bit cl;
    runs = 0;
    if (n < 2 || n > 4) return all;
    cl = closed && (n > 2);
    ne = n - 1 + (cl ? 1 : 0);
    for (int e = 0; e < ne; e++) begin
      b  = (e + 1) % n;
      ax = int'($signed(vx[e*12 +: 12]));
      ay = int'($signed(vy[e*12 +: 12]));
      bx = int'($signed(vx[b*12 +: 12]));
      by = int'($signed(vy[b*12 +: 12]));
      if (ax != bx || ay != by) runs++;
      seg = line_pts(ax, ay, bx, by);
      if (e > 0 && seg.size() > 0) void'(seg.pop_front());
      if (cl && e == ne - 1 && seg.size() > 0 && seg[$] == mkpt(bx, by)) void'(seg.pop_back());
      foreach (seg[i]) all.push_back(seg[i]);
    end
    return all;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Downstream monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (pix_valid && pix_ready) got_q.push_back({pix_x, pix_y});
    if (done) done_cnt++;
    if (cmd_error) err_cnt++;
    if (lg_run && !mon_prev_run) run_rise++;
    mon_prev_run = lg_run;
    if (lg_draw_busy) db_high++;
    if (lg_draw_busy != (pix_valid && !pix_ready && lg_pixel_data_rdy)) db_viol++;
    if (flush_watch && (pix_valid || (cmd_ready && lg_busy))) flush_viol++;
  end

  // Downstream ready pattern: 0 always ready, 1 toggling, 2 random.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = !pix_ready;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic issue(input int n, input bit closed, input logic [47:0] vx, input logic [47:0] vy);
    int t;
    t = 0;
    while (!cmd_ready && t < 300) begin @(posedge clk); #1; t++; end
    chk("cmd_ready_before_issue", int'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_nverts = n[2:0];
    cmd_closed = closed;
    cmd_vx     = vx;
    cmd_vy     = vy;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input int n, input bit closed, input logic [47:0] vx,
                         input logic [47:0] vy, input int mode, input int exp_cnt);
    ptq_t exp_q;
    int exp_runs, d0, r0, e0, t, bad;
    ready_mode = mode;
    exp_q = ref_pixels(n, closed, vx, vy, exp_runs);
    got_q.delete();
    d0 = done_cnt; r0 = run_rise; e0 = err_cnt;
    issue(n, closed, vx, vy);
    if (n < 2 || n > 4) begin
      repeat (3) @(posedge clk);
      #1;
      chk({tag, " cmd_error_pulses"}, err_cnt - e0, 1);
      chk({tag, " no_pixels"}, got_q.size(), 0);
      chk({tag, " cmd_ready_stays"}, int'(cmd_ready), 1);
      chk({tag, " no_done"}, done_cnt - d0, 0);
    end else begin
      t = 0;
      while (done_cnt == d0 && t < 3000) begin @(posedge clk); #1; t++; end
      chk({tag, " done_once"}, done_cnt - d0, 1);
      chk({tag, " busy_low_after_done"}, int'(busy), 0);
      chk({tag, " no_error"}, err_cnt - e0, 0);
      chk({tag, " run_count"}, run_rise - r0, exp_runs);
      if (exp_cnt >= 0) chk({tag, " pixel_count_vs_table"}, got_q.size(), exp_cnt);
      chk({tag, " pixel_count"}, got_q.size(), exp_q.size());
      bad = -1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
      if (bad >= 0)
        chk($sformatf("%s pixel[%0d] got %h exp %h first_bad_index", tag, bad, got_q[bad], exp_q[bad]), bad, -1);
      else
        chk({tag, " pixel_sequence"}, bad, -1);
    end
  endtask

  vec_t tbl[13];

  initial begin
    int t;
    tbl[0]  = '{2, 1'b0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 4};
    tbl[1]  = '{3, 1'b1, 0, 0, 4, 0, 0, 4, 0, 0, 0, 12};
    tbl[2]  = '{2, 1'b0, 0, 0, 3, 1, 0, 0, 0, 0, 1, 4};
    tbl[3]  = '{3, 1'b1, 0, 0, 4, 0, 0, 4, 0, 0, 2, 12};
    tbl[4]  = '{4, 1'b1, 0, 0, 3, 0, 3, 3, 0, 3, 2, 12};
    tbl[5]  = '{3, 1'b0, -5, -2, 2, -6, 2, 1, 0, 0, 1, 15};
    tbl[6]  = '{2, 1'b1, 1, 1, 4, 4, 0, 0, 0, 0, 0, 4};
    tbl[7]  = '{1, 1'b0, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{5, 1'b1, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};
    tbl[9]  = '{0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{2, 1'b0, 5, 5, 5, 5, 0, 0, 0, 0, 1, 1};
    tbl[11] = '{3, 1'b0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 3};
    tbl[12] = '{3, 1'b1, 0, 0, 2, 0, 2, 0, 0, 0, 2, 4};

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cmd_ready", int'(cmd_ready), 0);
    chk("rst lg_run", int'(lg_run), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst cmd_error", int'(cmd_error), 0);
    chk("rst pix_valid", int'(pix_valid), 0);
    chk("rst lg_endpoints", int'({lg_aX, lg_aY, lg_bX, lg_bY} != 48'd0), 0);
    chk("tied_offs", int'({lg_pass_thru_a, lg_pass_thru_b, lg_ena_stop_y, lg_stop_ypos} != 15'd0), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (tbl[i])
      run_cmd($sformatf("vec%0d", i), tbl[i].n, tbl[i].closed,
              pk(tbl[i].x0, tbl[i].x1, tbl[i].x2, tbl[i].x3),
              pk(tbl[i].y0, tbl[i].y1, tbl[i].y2, tbl[i].y3), tbl[i].mode, tbl[i].exp_cnt);

    for (int r = 0; r < 25; r++) begin
      int n, c[8];
      n = int'($urandom_range(2, 4));
      foreach (c[k]) c[k] = int'($urandom_range(0, 16)) - 8;
      run_cmd($sformatf("rnd%0d", r), n, 1'($urandom_range(0, 1)),
              pk(c[0], c[1], c[2], c[3]), pk(c[4], c[5], c[6], c[7]), 2, -1);
    end

    // Reset in the middle of a long edge: generator must drain before the next command.
    ready_mode = 0;
    got_q.delete();
    issue(2, 1'b0, pk(0, 100, 0, 0), pk(0, 0, 0, 0));
    repeat (30) @(posedge clk);
    #1;
    chk("midreset pixels_started", int'(got_q.size() > 0), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush_watch = 1'b1;
    chk("midreset lg_busy_still_high", int'(lg_busy), 1);
    chk("midreset cmd_ready_low", int'(cmd_ready), 0);
    chk("midreset lg_run_low", int'(lg_run), 0);
    chk("midreset busy_low", int'(busy), 0);
    t = 0;
    while (!cmd_ready && t < 300) begin @(posedge clk); #1; t++; end
    flush_watch = 1'b0;
    chk("midreset cmd_ready_returns", int'(cmd_ready), 1);
    chk("midreset lg_busy_drained", int'(lg_busy), 0);
    chk("midreset flush_quiet", flush_viol, 0);
    run_cmd("after_reset", 2, 1'b0, pk(0, 3, 0, 0), pk(0, 1, 0, 0), 0, 4);

    chk("draw_busy_track", db_viol, 0);
    chk("draw_busy_exercised", int'(db_high > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
